// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - op encodings and default latencies shared by the mul/div unit, decoder and stall logic
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } op_e;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    // MULT..DIVU occupy the lower half of the encoding space
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - E-stage request / HI-LO result bundle of the mul/div unit
interface muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_hi;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    modport master (
        output start, op, rs_val, rt_val, rd_hi,
        input  busy, hi, lo, rd_data
    );

    modport slave (
        input  start, op, rs_val, rt_val, rd_hi,
        output busy, hi, lo, rd_data
    );
endinterface

// File: rtl/muldiv_compute.sv
// rtl/muldiv_compute.sv - combinational signed/unsigned multiply and divide producing a {hi,lo} pair
module muldiv_compute
    import muldiv_unit_pkg::*;
(
    input  op_e         i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_hi64,
    output logic        o_div0
);

    logic               w_div0;
    logic               w_ovf;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic signed [31:0] w_sb_safe;
    logic        [31:0] w_ub_safe;
    logic        [63:0] w_sprod;
    logic        [63:0] w_uprod;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic        [31:0] w_uq;
    logic        [31:0] w_ur;

    assign w_sa   = i_a;
    assign w_sb   = i_b;
    assign w_div0 = (i_b == 32'd0);
    assign w_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Dividing by 1 instead of -1 yields exactly the wrapped quotient and zero remainder
    assign w_sb_safe = (w_div0 || w_ovf) ? 32'sd1 : w_sb;
    assign w_ub_safe = w_div0 ? 32'd1 : i_b;

    // Low 64 bits of the product of sign-extended operands equal the signed product
    assign w_sprod = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
    assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

    assign w_sq = w_sa / w_sb_safe;
    assign w_sr = w_sa % w_sb_safe;
    assign w_uq = i_a / w_ub_safe;
    assign w_ur = i_a % w_ub_safe;

    always_comb begin
        o_hi64 = 64'd0;
        o_div0 = 1'b0;
        case (i_op)
            OP_MULT:  o_hi64 = w_sprod;
            OP_MULTU: o_hi64 = w_uprod;
            OP_DIV: begin
                o_hi64 = {w_sr, w_sq};
                o_div0 = w_div0;
            end
            OP_DIVU: begin
                o_hi64 = {w_ur, w_uq};
                o_div0 = w_div0;
            end
            default: o_hi64 = 64'd0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO and the stall busy flag
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_unit_if.slave   mdu
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic [63:0]      r_pend;
    logic             r_pend_div0;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    op_e              w_op;
    logic             w_idle;
    logic [63:0]      w_res;
    logic             w_div0;

    assign w_op   = op_e'(mdu.op);
    assign w_idle = (r_cnt == '0);

    muldiv_compute u_compute (
        .i_op   (w_op),
        .i_a    (mdu.rs_val),
        .i_b    (mdu.rt_val),
        .o_hi64 (w_res),
        .o_div0 (w_div0)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_pend      <= 64'd0;
            r_pend_div0 <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
        end else if (!w_idle) begin
            // A start while counting is dropped; the stall logic never issues one
            if (r_cnt == CNT_ONE) begin
                r_cnt <= '0;
                if (!r_pend_div0) begin
                    {r_hi, r_lo} <= r_pend;
                end
            end else begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end else if (mdu.start) begin
            case (w_op)
                OP_MULT, OP_MULTU: begin
                    r_cnt       <= CNT_MUL;
                    r_pend      <= w_res;
                    r_pend_div0 <= 1'b0;
                end
                OP_DIV, OP_DIVU: begin
                    r_cnt       <= CNT_DIV;
                    r_pend      <= w_res;
                    r_pend_div0 <= w_div0;
                end
                OP_MTHI: r_hi <= mdu.rs_val;
                OP_MTLO: r_lo <= mdu.rs_val;
                default: ;
            endcase
        end
    end

    // The start term lets the instruction behind a mul/div stall in its issue cycle
    assign mdu.busy    = (mdu.start && is_muldiv(mdu.op)) || !w_idle;
    assign mdu.hi      = r_hi;
    assign mdu.lo      = r_lo;
    assign mdu.rd_data = mdu.rd_hi ? r_hi : r_lo;

    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n) !(mdu.start && !w_idle)
    ) else $warning("muldiv_unit: start while busy ignored");

endmodule
